pc_fetch_sequencer: RTL

- Owns the architectural PC register and sequences instruction fetch through a req/ack handshake to instruction memory.
- Each cycle it takes the combinational next-PC result (branch/jump/jr target) as its default next address.
- Overrides that address for exceptions, eret and misaligned targets, and holds on hazard stall.
- Sits between the next-PC unit, the instruction memory port and the CP0/EPC logic of the CPU.

---
 rtl/pc_fetch_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//
// Owns the architectural PC and sequences instruction fetch through a
// req/ack handshake to instruction memory. Each instruction goes through
// FETCH (request held until ack) and then ISSUE (instruction presented for
// execution). On leaving ISSUE the next PC is the next-PC unit result,
// the EPC on eret, or the exception vector on an exception or a misaligned
// target. A hazard stall holds the instruction in ISSUE.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   npc                next PC from the next-PC unit (used in ISSUE)
//   stall              hazard freeze, holds ISSUE
//   exc_req, eret      exception request / return-from-exception (ISSUE)
//   epc_in             saved EPC from CP0, target on eret
//   imem_req/addr      fetch request and address (address == pc)
//   imem_ack/rdata     memory response and instruction word
//   pc, instr          current instruction address and latched word
//   instr_valid        high while in ISSUE
//   epc_we, epc_out    one-cycle CP0 EPC write pulse and faulting PC
//   misaligned         one-cycle pulse when a selected target is misaligned
//   retire_cnt         wrapping count of ISSUE exits
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        misaligned,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    ISSUE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        epc_we_q, epc_we_d;
  logic [31:0] epc_out_q, epc_out_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] target;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    epc_out_d    = epc_out_q;
    retire_cnt_d = retire_cnt_q;
    epc_we_d     = 1'b0;
    misaligned_d = 1'b0;
    target       = eret ? epc_in : npc;

    case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Exceptions outrank the stall so a frozen pipeline can still trap.
        if (exc_req) begin
          pc_d         = EXC_VECTOR;
          epc_out_d    = pc_q;
          epc_we_d     = 1'b1;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = FETCH;
        end else if (!stall) begin
          if (target[1:0] != 2'b00) begin
            pc_d         = EXC_VECTOR;
            epc_out_d    = pc_q;
            epc_we_d     = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            pc_d = target;
          end
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase

    // Request and valid are registered copies of the state being entered.
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      epc_we_q      <= 1'b0;
      epc_out_q     <= '0;
      misaligned_q  <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      epc_we_q      <= epc_we_d;
      epc_out_q     <= epc_out_d;
      misaligned_q  <= misaligned_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign epc_we      = epc_we_q;
  assign epc_out     = epc_out_q;
  assign misaligned  = misaligned_q;
  assign retire_cnt  = retire_cnt_q;

endmodule
